// File: rtl/result_port_arbiter_if.sv
// result_port_arbiter_if
// Bundles the requester-side handshake, the branch-flush strobe and the
// writeback-port signals of the result port arbiter.
//   master : drives requests, flush strobe and port-ready; sees grants and
//            the registered result.
//   slave  : the arbiter itself.
// Signals:
//   IN_branchTaken / IN_branchSqN        branch flush strobe and its sequence number
//   IN_reqValid / IN_reqExternal         per-requester valid and flush-exempt bits
//   IN_reqSqN / IN_reqTag / IN_reqData   per-requester payload, packed by index
//   IN_reqDnc                            per-requester doNotCommit
//   OUT_reqReady                         one-hot grant, combinational
//   IN_portReady                         writeback port accepts this cycle
//   OUT_res*                             registered result and source index
interface result_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int SQN_W   = 7,
  parameter int TAG_W   = 7,
  parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic                     IN_branchTaken;
  logic [SQN_W-1:0]         IN_branchSqN;
  logic [NUM_REQ-1:0]       IN_reqValid;
  logic [NUM_REQ-1:0]       IN_reqExternal;
  logic [NUM_REQ*SQN_W-1:0] IN_reqSqN;
  logic [NUM_REQ*TAG_W-1:0] IN_reqTag;
  logic [NUM_REQ*32-1:0]    IN_reqData;
  logic [NUM_REQ-1:0]       IN_reqDnc;
  logic [NUM_REQ-1:0]       OUT_reqReady;
  logic                     IN_portReady;
  logic                     OUT_resValid;
  logic [TAG_W-1:0]         OUT_resTag;
  logic [31:0]              OUT_resData;
  logic                     OUT_resDnc;
  logic [SQN_W-1:0]         OUT_resSqN;
  logic [SRC_W-1:0]         OUT_resSrc;

  modport master (
    output IN_branchTaken, IN_branchSqN, IN_reqValid, IN_reqExternal,
    output IN_reqSqN, IN_reqTag, IN_reqData, IN_reqDnc, IN_portReady,
    input  OUT_reqReady, OUT_resValid, OUT_resTag, OUT_resData,
    input  OUT_resDnc, OUT_resSqN, OUT_resSrc
  );

  modport slave (
    input  IN_branchTaken, IN_branchSqN, IN_reqValid, IN_reqExternal,
    input  IN_reqSqN, IN_reqTag, IN_reqData, IN_reqDnc, IN_portReady,
    output OUT_reqReady, OUT_resValid, OUT_resTag, OUT_resData,
    output OUT_resDnc, OUT_resSqN, OUT_resSrc
  );
endinterface

// File: rtl/result_port_arbiter.sv
// result_port_arbiter
// Picks one of NUM_REQ result requesters per cycle (starvation override first,
// round-robin otherwise) and registers the winner into a one-entry output
// stage feeding a writeback port. Granted requests killed by a branch flush
// are consumed but not forwarded; a held output killed by a flush is dropped.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : result_port_arbiter_if.slave (requests, flush, grant, result)
module result_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int SQN_W      = 7,
  parameter int TAG_W      = 7,
  parameter int STARVE_LIM = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  result_port_arbiter_if.slave  bus
);

  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM_C  = CNT_W'(STARVE_LIM);
  localparam logic [SRC_W-1:0] LAST_C = SRC_W'(NUM_REQ - 1);

  // Younger when the wrapped difference, read as signed, is strictly positive.
  function automatic logic is_younger(input logic [SQN_W-1:0] sqn,
                                      input logic [SQN_W-1:0] br_sqn);
    logic [SQN_W-1:0] diff;
    diff = sqn - br_sqn;
    return (diff != {SQN_W{1'b0}}) && !diff[SQN_W-1];
  endfunction

  logic [SRC_W-1:0]   rr_ptr_r;
  logic [CNT_W-1:0]   wait_cnt_r [NUM_REQ];
  logic               res_valid_r;
  logic               res_ext_r;
  logic [TAG_W-1:0]   res_tag_r;
  logic [31:0]        res_data_r;
  logic               res_dnc_r;
  logic [SQN_W-1:0]   res_sqn_r;
  logic [SRC_W-1:0]   res_src_r;

  logic               can_load_s;
  logic               starve_hit_s;
  logic [SRC_W-1:0]   starve_idx_s;
  logic               rr_hit_s;
  logic [SRC_W-1:0]   rr_idx_s;
  logic               xfer_s;
  logic [SRC_W-1:0]   grant_idx_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [SQN_W-1:0]   sel_sqn_s;
  logic               sel_ext_s;
  logic               sel_dead_s;
  logic               hold_flush_s;

  assign can_load_s = !res_valid_r || bus.IN_portReady;

  // Arbitration: starved requester (lowest index) first, else round-robin from rr_ptr_r.
  always_comb begin
    starve_hit_s = 1'b0;
    starve_idx_s = {SRC_W{1'b0}};
    rr_hit_s     = 1'b0;
    rr_idx_s     = {SRC_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!starve_hit_s && bus.IN_reqValid[i] && (wait_cnt_r[i] >= LIM_C)) begin
        starve_hit_s = 1'b1;
        starve_idx_s = SRC_W'(i);
      end else begin
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_r) + k) % NUM_REQ;
      if (!rr_hit_s && bus.IN_reqValid[idx]) begin
        rr_hit_s = 1'b1;
        rr_idx_s = SRC_W'(idx);
      end else begin
      end
    end
    // Grants are suppressed during reset so a pending request survives it.
    if (rst_n && can_load_s && starve_hit_s) begin
      xfer_s      = 1'b1;
      grant_idx_s = starve_idx_s;
    end else if (rst_n && can_load_s && rr_hit_s) begin
      xfer_s      = 1'b1;
      grant_idx_s = rr_idx_s;
    end else begin
      xfer_s      = 1'b0;
      grant_idx_s = {SRC_W{1'b0}};
    end
    if (xfer_s) begin
      grant_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      grant_s = {NUM_REQ{1'b0}};
    end
  end

  assign sel_sqn_s    = bus.IN_reqSqN[grant_idx_s*SQN_W +: SQN_W];
  assign sel_ext_s    = bus.IN_reqExternal[grant_idx_s];
  assign sel_dead_s   = bus.IN_branchTaken && !sel_ext_s &&
                        is_younger(sel_sqn_s, bus.IN_branchSqN);
  assign hold_flush_s = bus.IN_branchTaken && res_valid_r && !res_ext_r &&
                        is_younger(res_sqn_r, bus.IN_branchSqN);

  // Round-robin pointer advances past the winner on every transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= {SRC_W{1'b0}};
    end else if (xfer_s) begin
      rr_ptr_r <= (grant_idx_s == LAST_C) ? {SRC_W{1'b0}} : grant_idx_s + SRC_W'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Per-requester wait counters: count blocked cycles, saturate at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) wait_cnt_r[i] <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!bus.IN_reqValid[i] || grant_s[i]) begin
          wait_cnt_r[i] <= {CNT_W{1'b0}};
        end else if (wait_cnt_r[i] < LIM_C) begin
          wait_cnt_r[i] <= wait_cnt_r[i] + CNT_W'(1);
        end else begin
          wait_cnt_r[i] <= wait_cnt_r[i];
        end
      end
    end
  end

  // Output stage: load on transfer, drain when accepted, drop on flush while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_ext_r   <= 1'b0;
      res_tag_r   <= {TAG_W{1'b0}};
      res_data_r  <= 32'h0000_0000;
      res_dnc_r   <= 1'b0;
      res_sqn_r   <= {SQN_W{1'b0}};
      res_src_r   <= {SRC_W{1'b0}};
    end else if (xfer_s) begin
      res_valid_r <= !sel_dead_s;
      res_ext_r   <= sel_ext_s;
      res_tag_r   <= bus.IN_reqTag[grant_idx_s*TAG_W +: TAG_W];
      res_data_r  <= bus.IN_reqData[grant_idx_s*32 +: 32];
      res_dnc_r   <= bus.IN_reqDnc[grant_idx_s];
      res_sqn_r   <= sel_sqn_s;
      res_src_r   <= grant_idx_s;
    end else if (can_load_s || hold_flush_s) begin
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= res_valid_r;
    end
  end

  assign bus.OUT_reqReady = grant_s;
  assign bus.OUT_resValid = res_valid_r;
  assign bus.OUT_resTag   = res_tag_r;
  assign bus.OUT_resData  = res_data_r;
  assign bus.OUT_resDnc   = res_dnc_r;
  assign bus.OUT_resSqN   = res_sqn_r;
  assign bus.OUT_resSrc   = res_src_r;

endmodule

// File: tb/tb_result_port_arbiter.sv
// tb_result_port_arbiter
// Directed bench for result_port_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for reset, starvation and mid-stream reset.
module tb_result_port_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  result_port_arbiter_if #(.NUM_REQ(4), .SQN_W(7), .TAG_W(7)) bus ();

  result_port_arbiter #(.NUM_REQ(4), .SQN_W(7), .TAG_W(7), .STARVE_LIM(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic [3:0] ext;
    logic       pr;
    logic       bt;
    logic [6:0] bsq;
    logic [6:0] sqn;
    logic [3:0] rdy;
    logic       val;
    logic [1:0] src;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] ext, input logic pr,
                       input logic bt, input logic [6:0] bsq, input logic [6:0] sqn);
    bus.IN_reqValid    = v;
    bus.IN_reqExternal = ext;
    bus.IN_portReady   = pr;
    bus.IN_branchTaken = bt;
    bus.IN_branchSqN   = bsq;
    bus.IN_reqSqN      = {sqn, sqn, sqn, sqn};
  endtask

  // Checks the full registered result against the payload of requester src.
  task automatic check_out(input string name, input logic [1:0] src, input logic [6:0] sqn);
    logic [6:0]  etag;
    logic [31:0] edata;
    etag  = 7'h10 + {5'b00000, src};
    edata = 32'hA000_0000 + {30'd0, src};
    check({name, "_val"},  bus.OUT_resValid, 1'b1);
    check({name, "_src"},  bus.OUT_resSrc, src);
    check({name, "_tag"},  bus.OUT_resTag, etag);
    check({name, "_data"}, bus.OUT_resData, edata);
    check({name, "_dnc"},  bus.OUT_resDnc, (src == 2'd1));
    check({name, "_sqn"},  bus.OUT_resSqN, sqn);
  endtask

  task automatic apply_vec(input vec_t t, input int n);
    drive(t.v, t.ext, t.pr, t.bt, t.bsq, t.sqn);
    #1;
    check($sformatf("v%0d_rdy", n), bus.OUT_reqReady, t.rdy);
    @(posedge clk);
    #1;
    if (t.val) begin
      check_out($sformatf("v%0d", n), t.src, t.sqn);
    end else begin
      check($sformatf("v%0d_val", n), bus.OUT_resValid, 1'b0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst_n = 1'b1;
    bus.IN_reqTag  = {7'h13, 7'h12, 7'h11, 7'h10};
    bus.IN_reqData = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    bus.IN_reqDnc  = 4'b0010;
    drive(4'b0000, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h00);

    //              v        ext      pr    bt    bsq    sqn    rdy      val   src
    tbl[0]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h00, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h00, 4'b0010, 1'b1, 2'd1};
    tbl[2]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h00, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h00, 4'b1000, 1'b1, 2'd3};
    tbl[4]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h00, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h00, 4'b0100, 1'b1, 2'd2};
    tbl[6]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 7'h00, 7'h00, 4'b0000, 1'b1, 2'd2};
    tbl[7]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 7'h00, 7'h00, 4'b0000, 1'b1, 2'd2};
    tbl[8]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 7'h00, 7'h00, 4'b0000, 1'b1, 2'd2};
    tbl[9]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h00, 4'b0100, 1'b1, 2'd2};
    tbl[10] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h00, 4'b0000, 1'b0, 2'd0};
    // Held output sqN 5 flushed by branch 3; then the same with external set.
    tbl[11] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h05, 4'b0001, 1'b1, 2'd0};
    tbl[12] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 7'h03, 7'h05, 4'b0000, 1'b0, 2'd0};
    tbl[13] = '{4'b0001, 4'b0001, 1'b1, 1'b0, 7'h00, 7'h05, 4'b0001, 1'b1, 2'd0};
    tbl[14] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 7'h03, 7'h05, 4'b0000, 1'b1, 2'd0};
    tbl[15] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h05, 4'b0000, 1'b0, 2'd0};
    // sqN 0x02 vs branch 0x7F wraps to younger: consumed and dropped.
    tbl[16] = '{4'b0010, 4'b0000, 1'b1, 1'b1, 7'h7F, 7'h02, 4'b0010, 1'b0, 2'd0};
    // Equal sqN is not younger: kept.
    tbl[17] = '{4'b0010, 4'b0000, 1'b1, 1'b1, 7'h02, 7'h02, 4'b0010, 1'b1, 2'd1};
    // Flush with a same-cycle transfer only judges the new (external) entry.
    tbl[18] = '{4'b1000, 4'b1000, 1'b1, 1'b1, 7'h01, 7'h10, 4'b1000, 1'b1, 2'd3};
    tbl[19] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h00, 4'b0000, 1'b0, 2'd0};

    // Reset with a request pending: no grant, all outputs zero, granted after release.
    #2;
    rst_n = 1'b0;
    drive(4'b0100, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h09);
    #1;
    check("rst_val",  bus.OUT_resValid, 1'b0);
    check("rst_tag",  bus.OUT_resTag, 7'h00);
    check("rst_data", bus.OUT_resData, 32'h0);
    check("rst_sqn",  bus.OUT_resSqN, 7'h00);
    check("rst_dnc",  bus.OUT_resDnc, 1'b0);
    check("rst_src",  bus.OUT_resSrc, 2'd0);
    check("rst_rdy",  bus.OUT_reqReady, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_rdy", bus.OUT_reqReady, 4'b0000);
    check("rst_hold_val", bus.OUT_resValid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_rdy", bus.OUT_reqReady, 4'b0100);
    @(posedge clk);
    #1;
    check_out("rel", 2'd2, 7'h09);

    // Fresh reset so the table starts from rrPtr 0.
    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      apply_vec(tbl[i], i);
    end

    // Starvation: req 3 stalls behind a held output, then beats round-robin.
    drive(4'b1000, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h00);
    #1;
    check("stv_load_rdy", bus.OUT_reqReady, 4'b1000);
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      #1;
      drive(4'b1000, 4'b0000, 1'b0, 1'b0, 7'h00, 7'h00);
      #1;
      check($sformatf("stv_stall%0d_rdy", i), bus.OUT_reqReady, 4'b0000);
      @(posedge clk);
    end
    #1;
    drive(4'b1011, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h00);
    #1;
    check("stv_w7_rdy", bus.OUT_reqReady, 4'b0001);
    @(posedge clk);
    #1;
    check_out("stv_w7", 2'd0, 7'h00);
    check("stv_w8_rdy", bus.OUT_reqReady, 4'b1000);
    @(posedge clk);
    #1;
    check_out("stv_w8", 2'd3, 7'h00);

    // Mid-stream asynchronous reset, then grants restart at requester 0.
    drive(4'b1111, 4'b0000, 1'b1, 1'b0, 7'h00, 7'h00);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_val", bus.OUT_resValid, 1'b0);
    check("mid_rst_rdy", bus.OUT_reqReady, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_rdy", bus.OUT_reqReady, 4'b0001);
    @(posedge clk);
    #1;
    check_out("mid_rel", 2'd0, 7'h00);
    check("mid_next_rdy", bus.OUT_reqReady, 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
